// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store front end for a byte-addressed, big-endian memory that only
// transfers full 32-bit words and has a one-cycle registered read.
// - Checks alignment/size at accept; errors complete without touching memory.
// - Loads: read the word, extract the big-endian lane, sign/zero extend.
// - Word stores: write directly.
// - Byte/halfword stores: read-modify-write of the containing word.
//
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write, req_size     store flag; size 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned            loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata     byte address; right-justified store data
//   resp_valid/err/rdata    one-cycle completion pulse, error flag, load result
//   mem_read, mem_write     one-cycle strobes to memory
//   mem_address             word-aligned address to memory
//   mem_wdata, mem_rdata    write data to / read data from memory
module mem_access_unit #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic                    write_reg;
  logic [1:0]              size_reg;
  logic                    uns_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [15:0]             wdata_reg;
  logic                    err_reg;
  logic [31:0]             rdata_reg;
  logic [31:0]             mem_wdata_reg;

  logic                    accept;
  logic                    req_bad;
  logic [1:0]              offset;
  logic [7:0]              rd_lane [4];
  logic [7:0]              merged_lane [4];
  logic [31:0]             merged_word;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             load_ext;

  assign accept = req_valid && (state_reg == S_IDLE);
  assign offset = addr_reg[1:0];

  // Illegal size, odd halfword, or word not on a 4-byte boundary.
  assign req_bad = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Big-endian lanes: lane 0 is the byte at the lowest address, bits [31:24].
  // A store lane is replaced when it falls inside the addressed byte/half;
  // for halves the even lane takes the upper store byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit;
      logic [7:0] new_byte;
      assign rd_lane[gi] = mem_rdata[31-8*gi -: 8];
      assign hit = ((size_reg == 2'b00) && (offset == LANE)) ||
                   ((size_reg == 2'b01) && (offset[1] == LANE[1]));
      assign new_byte = ((size_reg == 2'b01) && !LANE[0]) ? wdata_reg[15:8]
                                                          : wdata_reg[7:0];
      assign merged_lane[gi] = hit ? new_byte : rd_lane[gi];
    end
  endgenerate

  assign merged_word = {merged_lane[0], merged_lane[1], merged_lane[2], merged_lane[3]};

  always_comb begin
    byte_sel = rd_lane[offset];
    half_sel = offset[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (size_reg)
      2'b00:   load_ext = {{24{~uns_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{~uns_reg & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_next = S_RESP;
          end else if (req_write && (req_size == 2'b10)) begin
            state_next = S_WR;
          end else begin
            state_next = S_RD;
          end
        end
      end
      S_RD:    state_next = S_WAIT;
      S_WAIT:  state_next = write_reg ? S_WR : S_RESP;
      S_WR:    state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    req_ready  = (state_reg == S_IDLE);
    mem_read   = (state_reg == S_RD);
    mem_write  = (state_reg == S_WR);
    resp_valid = (state_reg == S_RESP);
    resp_err   = (state_reg == S_RESP) && err_reg;
  end

  // Request capture and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_reg     <= 1'b0;
      size_reg      <= 2'b00;
      uns_reg       <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      mem_wdata_reg <= '0;
    end else begin
      if (accept) begin
        write_reg <= req_write;
        size_reg  <= req_size;
        uns_reg   <= req_unsigned;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata[15:0];
        err_reg   <= req_bad;
        rdata_reg <= '0;
        // Word stores go straight to WR, so their data is staged now.
        if (req_write) begin
          mem_wdata_reg <= req_wdata;
        end
      end
      if (state_reg == S_WAIT) begin
        if (write_reg) begin
          mem_wdata_reg <= merged_word;
        end else begin
          rdata_reg <= load_ext;
        end
      end
    end
  end

  assign resp_rdata  = rdata_reg;
  assign mem_wdata   = mem_wdata_reg;
  // Derived from the captured address, so it is stable for the whole access.
  assign mem_address = {addr_reg[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural big-endian
// word memory (one-cycle registered read).
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  mem_access_unit #(.ADDR_WIDTH(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  // Memory model; pre_we lets the bench preload words through the same process.
  logic [7:0]  mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'h00;
  logic [31:0] pre_data = 32'h0;

  always @(posedge clock) begin
    if (pre_we) begin
      mem[pre_addr]        <= pre_data[31:24];
      mem[pre_addr + 8'd1] <= pre_data[23:16];
      mem[pre_addr + 8'd2] <= pre_data[15:8];
      mem[pre_addr + 8'd3] <= pre_data[7:0];
    end else if (mem_write) begin
      mem[mem_address]        <= mem_wdata[31:24];
      mem[mem_address + 8'd1] <= mem_wdata[23:16];
      mem[mem_address + 8'd2] <= mem_wdata[15:8];
      mem[mem_address + 8'd3] <= mem_wdata[7:0];
    end
    if (mem_read) begin
      mem_rdata <= {mem[mem_address], mem[mem_address + 8'd1],
                    mem[mem_address + 8'd2], mem[mem_address + 8'd3]};
    end
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  // Issue one request and follow it to its response. lat counts edges from
  // the accept edge (inclusive) to the edge that produces resp_valid.
  task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                        input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nrd, output int nwr,
                        output logic [7:0] waddr, output logic [31:0] wdat);
    int k;
    nrd = 0; nwr = 0; lat = 0; waddr = 8'h00; wdat = 32'h0; rdata = 32'h0; err = 1'b0;
    k = 0;
    @(negedge clock);
    while (!req_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    req_valid = 1'b1;
    req_write = w;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      if (mem_write) begin
        waddr = mem_address;
        wdat = mem_wdata;
      end
      @(posedge clock);
      #1;
      lat++;
    end
    nrd += int'(mem_read);
    nwr += int'(mem_write);
    if (!resp_valid) lat = 99;
    rdata = resp_rdata;
    err = resp_err;
    $display("op w=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d rd=%0d wr=%0d",
             w, sz, u, a, wd, rdata, err, lat, nrd, nwr);
  endtask

  logic [31:0] rd, wdat;
  logic        er;
  logic [7:0]  wa;
  int          lat, nrd, nwr, k;

  initial begin
    // Reset values, checked while reset is asserted
    #1;
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst mem_read", 32'(mem_read), 32'd0);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst mem_address", 32'(mem_address), 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);

    preload(8'h00, 32'hCAFEF00D);
    preload(8'h10, 32'h8899AABB);
    preload(8'h20, 32'h11223344);
    preload(8'h30, 32'h55667788);
    preload(8'hFC, 32'hA5A5A5A5);
    @(negedge clock);
    reset_n = 1'b1;

    // Word load
    run_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lw10 rdata", rd, 32'h8899AABB);
    chk("lw10 err", 32'(er), 32'd0);
    chk("lw10 lat", 32'(lat), 32'd3);
    chk("lw10 nrd", 32'(nrd), 32'd1);
    chk("lw10 nwr", 32'(nwr), 32'd0);
    @(posedge clock); #1;
    chk("lw10 hold rdata", resp_rdata, 32'h8899AABB);

    // Sub-word loads
    run_op(1'b0, 2'b00, 1'b0, 8'h11, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lb11 signed", rd, 32'hFFFFFF99);
    chk("lb11 lat", 32'(lat), 32'd3);
    run_op(1'b0, 2'b00, 1'b1, 8'h11, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lbu11", rd, 32'h00000099);
    run_op(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lh12 signed", rd, 32'hFFFFAABB);
    run_op(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lhu12", rd, 32'h0000AABB);
    run_op(1'b0, 2'b01, 1'b1, 8'h10, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lhu10", rd, 32'h00008899);
    run_op(1'b0, 2'b00, 1'b0, 8'h12, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lb12 signed", rd, 32'hFFFFFFAA);
    run_op(1'b0, 2'b00, 1'b0, 8'h23, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lb23 positive", rd, 32'h00000044);

    // Byte store (read-modify-write)
    run_op(1'b1, 2'b00, 1'b0, 8'h13, 32'hFFFFFF5A, rd, er, lat, nrd, nwr, wa, wdat);
    chk("sb13 lat", 32'(lat), 32'd4);
    chk("sb13 nrd", 32'(nrd), 32'd1);
    chk("sb13 nwr", 32'(nwr), 32'd1);
    chk("sb13 mem_address", 32'(wa), 32'h10);
    chk("sb13 mem_wdata", wdat, 32'h8899AA5A);
    chk("sb13 rdata", rd, 32'h0);
    chk("sb13 err", 32'(er), 32'd0);
    run_op(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lw10 after sb", rd, 32'h8899AA5A);

    // Halfword store at offset 0
    run_op(1'b1, 2'b01, 1'b0, 8'h10, 32'hABCD1234, rd, er, lat, nrd, nwr, wa, wdat);
    chk("sh10 mem_wdata", wdat, 32'h1234AA5A);
    chk("sh10 lat", 32'(lat), 32'd4);
    chk("sh10 model word", mem_word(8'h10), 32'h1234AA5A);

    // Error cases
    run_op(1'b0, 2'b10, 1'b0, 8'h12, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lw12 err", 32'(er), 32'd1);
    chk("lw12 lat", 32'(lat), 32'd1);
    chk("lw12 strobes", 32'(nrd + nwr), 32'd0);
    chk("lw12 rdata", rd, 32'h0);
    run_op(1'b0, 2'b01, 1'b0, 8'h11, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lh11 err", 32'(er), 32'd1);
    chk("lh11 lat", 32'(lat), 32'd1);
    chk("lh11 strobes", 32'(nrd + nwr), 32'd0);
    run_op(1'b0, 2'b11, 1'b0, 8'h10, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("sz11 err", 32'(er), 32'd1);
    chk("sz11 lat", 32'(lat), 32'd1);
    chk("sz11 strobes", 32'(nrd + nwr), 32'd0);
    run_op(1'b1, 2'b10, 1'b0, 8'h11, 32'hDEADDEAD, rd, er, lat, nrd, nwr, wa, wdat);
    chk("sw11 err", 32'(er), 32'd1);
    chk("sw11 strobes", 32'(nrd + nwr), 32'd0);
    chk("sw11 model word", mem_word(8'h10), 32'h1234AA5A);

    // Top-of-memory word store and load
    run_op(1'b1, 2'b10, 1'b0, 8'hFC, 32'h01020304, rd, er, lat, nrd, nwr, wa, wdat);
    chk("swFC lat", 32'(lat), 32'd2);
    chk("swFC nrd", 32'(nrd), 32'd0);
    chk("swFC nwr", 32'(nwr), 32'd1);
    chk("swFC mem_address", 32'(wa), 32'hFC);
    chk("swFC mem_wdata", wdat, 32'h01020304);
    run_op(1'b0, 2'b10, 1'b0, 8'hFC, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lwFC rdata", rd, 32'h01020304);
    chk("word 00 untouched", mem_word(8'h00), 32'hCAFEF00D);
    run_op(1'b0, 2'b00, 1'b1, 8'hFF, 32'h0, rd, er, lat, nrd, nwr, wa, wdat);
    chk("lbuFF", rd, 32'h00000004);

    // req_valid held high through a busy load; the changed request must be ignored
    @(negedge clock);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = 2'b10;
    req_unsigned = 1'b0;
    req_addr = 8'h10;
    @(posedge clock); #1;
    req_write = 1'b1;
    req_addr = 8'h30;
    req_wdata = 32'hFFFFFFFF;
    nrd = 0; nwr = 0; lat = 1;
    while (!resp_valid && lat < 20) begin
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      @(posedge clock); #1;
      lat++;
    end
    req_valid = 1'b0;
    chk("busy lat", 32'(lat), 32'd3);
    chk("busy rdata", resp_rdata, 32'h1234AA5A);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      nrd += int'(mem_read);
      nwr += int'(mem_write);
    end
    $display("busy hold: rd=%0d wr=%0d ready=%0d", nrd, nwr, req_ready);
    chk("busy nrd", 32'(nrd), 32'd1);
    chk("busy nwr", 32'(nwr), 32'd0);
    chk("busy ready after", 32'(req_ready), 32'd1);
    chk("busy word 30", mem_word(8'h30), 32'h55667788);

    // Reset in WAIT of a byte store
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b00;
    req_addr = 8'h21;
    req_wdata = 32'h000000EE;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("pre-reset mem_address", 32'(mem_address), 32'h20);
    reset_n = 1'b0;
    #1;
    chk("mid-rst req_ready", 32'(req_ready), 32'd1);
    chk("mid-rst resp_valid", 32'(resp_valid), 32'd0);
    chk("mid-rst mem_write", 32'(mem_write), 32'd0);
    chk("mid-rst mem_read", 32'(mem_read), 32'd0);
    chk("mid-rst mem_address", 32'(mem_address), 32'h0);
    chk("mid-rst mem_wdata", mem_wdata, 32'h0);
    chk("mid-rst resp_rdata", resp_rdata, 32'h0);
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      nwr += int'(mem_write);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      nwr += int'(mem_write);
    end
    $display("reset abort: wr=%0d word20=%h", nwr, mem_word(8'h20));
    chk("rst-abort nwr", 32'(nwr), 32'd0);
    chk("rst-abort word 20", mem_word(8'h20), 32'h11223344);
    chk("rst-abort ready", 32'(req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end placed directly upstream of the byte-addressed, big-endian `Memory` block. It accepts byte, halfword and word requests from the CPU datapath and checks alignment. It sequences the memory's one-cycle registered read, and performs read-modify-write for sub-word stores, since the memory only transfers full 4-byte words. Load results are sign- or zero-extended and returned with a single-cycle response pulse.

## Interface
- `ADDR_WIDTH`, default 8: byte address width; must equal the memory's address width.

- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle; a request is accepted on an edge where `req_valid & req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  ADDR_WIDTH  byte address
- `req_wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_err`  out  1  valid with `resp_valid`: misaligned or illegal size
- `resp_rdata`  out  32  extended load data; valid with `resp_valid` and held until the next accept
- `mem_read`  out  1  to memory `mem_read`
- `mem_write`  out  1  to memory `mem_write`
- `mem_address`  out  ADDR_WIDTH  always word-aligned: `{addr[ADDR_WIDTH-1:2], 2'b00}`
- `mem_wdata`  out  32  to memory `data_in`
- `mem_rdata`  in  32  from memory `data_out`

## Operation
- States: IDLE, RD, WAIT, WR, RESP.
- `req_ready` = (state == IDLE). Requests arriving in any other state are ignored with no side effects.
- On accept, register `req_write`, `req_size`, `req_unsigned`, `req_addr` and `req_wdata`.
- Error check at accept:
  - Size 11 is an error.
  - Halfword with `addr[0]` = 1 is an error.
  - Word with `addr[1:0]` ≠ 0 is an error.
  - On error: IDLE→RESP with `resp_err` = 1, `resp_rdata` = 0, and no memory strobe.
- Load path: IDLE→RD→WAIT→RESP.
  - RD drives `mem_read` = 1.
  - In WAIT, `mem_rdata` is valid. Extract the lane and register the extended result.
- Word store: IDLE→WR→RESP. WR drives `mem_write` = 1 with `mem_wdata` = `req_wdata`.
- Byte or halfword store: IDLE→RD→WAIT→WR→RESP.
  - In WAIT, merge the new lane into `mem_rdata` and register the result as `mem_wdata`.
  - WR writes the full word back.
- Lane selection is big-endian on offset `k = addr[1:0]`:
  - Byte k = `word[31-8k -: 8]`.
  - Halfword at offset 0 = [31:16]; at offset 2 = [15:0].
- Extension: sign bit is the lane MSB when `req_unsigned` = 0; otherwise zero-fill. Stores return `resp_rdata` = 0.
- RESP lasts one cycle (`resp_valid` = 1, no back-pressure), then returns to IDLE.
- `mem_read` and `mem_write` are Moore outputs decoded from state, never simultaneously 1, and each high for exactly one cycle per access.
- `mem_address` is held stable from RD or WR through the end of the operation.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, `req_ready` = 1.
  - `resp_valid`, `resp_err`, `mem_read`, `mem_write` = 0.
  - `resp_rdata`, `mem_address`, `mem_wdata` = 0.
- Latency, counted from the accept edge to the cycle with `resp_valid` = 1:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- The earliest next accept is the edge after RESP; `req_ready` rises in the cycle following `resp_valid`.
- Reset mid-operation aborts immediately:
  - A pending WR never asserts `mem_write`, so memory is unchanged.
  - If reset lands during RD, a memory read already captured is harmless and is discarded.
- Top-of-memory access (`addr` 0xFC–0xFF): the aligned base is 0xFC, so no address wrap occurs.

## Test plan
- Preload word 0x10 = 0x8899AABB. Load word at 0x10 → `resp_rdata` = 0x8899AABB, `resp_err` = 0, `resp_valid` 3 cycles after accept, `mem_read` high exactly 1 cycle.
- Load byte at 0x11: signed → 0xFFFFFF99; unsigned → 0x00000099. Load half at 0x12: signed → 0xFFFFAABB; unsigned → 0x0000AABB.
- Store byte 0x5A at 0x13 → `mem_write` 1 cycle, `mem_address` = 0x10, `mem_wdata` = 0x8899AA5A, latency 4. A following load word at 0x10 returns 0x8899AA5A.
- Load word at 0x12, half at 0x11, and size 11 at 0x10 → each gives `resp_err` = 1 one cycle after accept, with `mem_read`/`mem_write` never asserted.
- Store word 0x01020304 at 0xFC, then load word at 0xFC → 0x01020304, and bytes 0x00–0x03 are untouched.
- Hold `req_valid` high through a busy load → only the first request is accepted. Assert `reset_n` = 0 in the WAIT of a byte store → outputs go to reset values immediately, `mem_write` never pulses, and memory is unchanged.
